// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter: two-master Wishbone arbiter merging the SPI programmer bus
// and the SERV CPU bus onto one shared program/data memory port.
// Round-robin arbitration with the grant locked until the transfer ends.
// Optional bus watchdog enabled by defining SERV_MEM_ARB_TIMEOUT_EN: a granted
// transfer that sees no memory ack for TIMEOUT_CYCLES cycles is terminated
// with a forced ack, read data 32'hDEADBEEF and a sticky o_timeout flag.

module serv_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic [31:0] i_wb_prog_adr,
    input  logic [31:0] i_wb_prog_dat,
    input  logic [3:0]  i_wb_prog_sel,
    input  logic        i_wb_prog_we,
    input  logic        i_wb_prog_cyc,
    output logic [31:0] o_wb_prog_rdt,
    output logic        o_wb_prog_ack,
    input  logic [31:0] i_wb_cpu_adr,
    input  logic [31:0] i_wb_cpu_dat,
    input  logic [3:0]  i_wb_cpu_sel,
    input  logic        i_wb_cpu_we,
    input  logic        i_wb_cpu_cyc,
    output logic [31:0] o_wb_cpu_rdt,
    output logic        o_wb_cpu_ack,
    output logic [31:0] o_wb_mem_adr,
    output logic [31:0] o_wb_mem_dat,
    output logic [3:0]  o_wb_mem_sel,
    output logic        o_wb_mem_we,
    output logic        o_wb_mem_cyc,
    input  logic [31:0] i_wb_mem_rdt,
    input  logic        i_wb_mem_ack,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROG = 2'd1,
        S_CPU  = 2'd2
    } state_e;

    localparam logic        LAST_PROG   = 1'b0;
    localparam logic        LAST_CPU    = 1'b1;
    localparam logic [31:0] TIMEOUT_RDT = 32'hDEADBEEF;

    // The watchdog must be able to see at least one wait cycle before firing
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("serv_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   gnt_cyc;
    logic   wd_fire;

    // Request line of whichever master currently holds the grant
    always_comb begin
        gnt_cyc = 1'b0;
        case (state_q)
            S_PROG:  gnt_cyc = i_wb_prog_cyc;
            S_CPU:   gnt_cyc = i_wb_cpu_cyc;
            default: gnt_cyc = 1'b0;
        endcase
    end

`ifdef SERV_MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;

    // Count granted cycles without an ack; fire on the last allowed one.
    // A real ack in the firing cycle wins, and an aborted transfer never fires.
    always_comb begin
        wd_fire   = gnt_cyc && !i_wb_mem_ack && (wd_cnt_q == CNT_LAST);
        wd_cnt_d  = wd_cnt_q;
        if (state_q == S_IDLE) begin
            wd_cnt_d = '0;
        end else if (!i_wb_mem_ack) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | wd_fire;
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Grant state and round-robin history register
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
            last_q  <= LAST_CPU;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next grant: round-robin on ties from IDLE, hold until ack/abort/watchdog
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (i_wb_prog_cyc && (!i_wb_cpu_cyc || (last_q == LAST_CPU))) begin
                    state_d = S_PROG;
                    last_d  = LAST_PROG;
                end else if (i_wb_cpu_cyc) begin
                    state_d = S_CPU;
                    last_d  = LAST_CPU;
                end
            end
            S_PROG, S_CPU: begin
                if (!gnt_cyc || i_wb_mem_ack || wd_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory bus mux, ack steering and read-data routing for the granted master
    always_comb begin
        o_wb_mem_adr  = '0;
        o_wb_mem_dat  = '0;
        o_wb_mem_sel  = '0;
        o_wb_mem_we   = 1'b0;
        o_wb_mem_cyc  = 1'b0;
        o_wb_prog_ack = 1'b0;
        o_wb_cpu_ack  = 1'b0;
        o_wb_prog_rdt = i_wb_mem_rdt;
        o_wb_cpu_rdt  = i_wb_mem_rdt;
        o_busy        = (state_q != S_IDLE);
        case (state_q)
            S_PROG: begin
                o_wb_mem_adr  = i_wb_prog_adr;
                o_wb_mem_dat  = i_wb_prog_dat;
                o_wb_mem_sel  = i_wb_prog_sel;
                o_wb_mem_we   = i_wb_prog_we;
                o_wb_mem_cyc  = i_wb_prog_cyc;
                o_wb_prog_ack = i_wb_mem_ack | wd_fire;
                if (wd_fire) begin
                    o_wb_prog_rdt = TIMEOUT_RDT;
                end
            end
            S_CPU: begin
                o_wb_mem_adr  = i_wb_cpu_adr;
                o_wb_mem_dat  = i_wb_cpu_dat;
                o_wb_mem_sel  = i_wb_cpu_sel;
                o_wb_mem_we   = i_wb_cpu_we;
                o_wb_mem_cyc  = i_wb_cpu_cyc;
                o_wb_cpu_ack  = i_wb_mem_ack | wd_fire;
                if (wd_fire) begin
                    o_wb_cpu_rdt = TIMEOUT_RDT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Testbench for serv_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transfer-level model.

module tb_serv_mem_arbiter;

    localparam int TO = 8;
`ifdef SERV_MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic [31:0] i_wb_prog_adr = '0, i_wb_prog_dat = '0;
    logic [3:0]  i_wb_prog_sel = '0;
    logic        i_wb_prog_we = 1'b0, i_wb_prog_cyc = 1'b0;
    logic [31:0] o_wb_prog_rdt;
    logic        o_wb_prog_ack;
    logic [31:0] i_wb_cpu_adr = '0, i_wb_cpu_dat = '0;
    logic [3:0]  i_wb_cpu_sel = '0;
    logic        i_wb_cpu_we = 1'b0, i_wb_cpu_cyc = 1'b0;
    logic [31:0] o_wb_cpu_rdt;
    logic        o_wb_cpu_ack;
    logic [31:0] o_wb_mem_adr, o_wb_mem_dat;
    logic [3:0]  o_wb_mem_sel;
    logic        o_wb_mem_we, o_wb_mem_cyc;
    logic [31:0] i_wb_mem_rdt = '0;
    logic        i_wb_mem_ack = 1'b0;
    logic        o_busy, o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serv_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .i_nrst(i_nrst),
        .i_wb_prog_adr(i_wb_prog_adr), .i_wb_prog_dat(i_wb_prog_dat),
        .i_wb_prog_sel(i_wb_prog_sel), .i_wb_prog_we(i_wb_prog_we),
        .i_wb_prog_cyc(i_wb_prog_cyc), .o_wb_prog_rdt(o_wb_prog_rdt),
        .o_wb_prog_ack(o_wb_prog_ack),
        .i_wb_cpu_adr(i_wb_cpu_adr), .i_wb_cpu_dat(i_wb_cpu_dat),
        .i_wb_cpu_sel(i_wb_cpu_sel), .i_wb_cpu_we(i_wb_cpu_we),
        .i_wb_cpu_cyc(i_wb_cpu_cyc), .o_wb_cpu_rdt(o_wb_cpu_rdt),
        .o_wb_cpu_ack(o_wb_cpu_ack),
        .o_wb_mem_adr(o_wb_mem_adr), .o_wb_mem_dat(o_wb_mem_dat),
        .o_wb_mem_sel(o_wb_mem_sel), .o_wb_mem_we(o_wb_mem_we),
        .o_wb_mem_cyc(o_wb_mem_cyc), .i_wb_mem_rdt(i_wb_mem_rdt),
        .i_wb_mem_ack(i_wb_mem_ack), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    typedef struct {
        logic        rst_n;
        logic        pc;
        logic        cc;
        logic        ack;
        logic [31:0] rdt;
        int          owner;  // 0 none, 1 programmer, 2 CPU
        logic        mcyc;
        logic        pack;
        logic        cack;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic r, input logic pc, input logic cc, input logic ack,
                                input logic [31:0] rdt, input int owner,
                                input logic mcyc, input logic pack, input logic cack);
        vec_t v;
        v.rst_n = r; v.pc = pc; v.cc = cc; v.ack = ack; v.rdt = rdt;
        v.owner = owner; v.mcyc = mcyc; v.pack = pack; v.cack = cack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of control inputs just after the rising edge, return at the falling edge
    task automatic set_in(input logic r, input logic pc, input logic cc, input logic ack,
                          input logic [31:0] rdt);
        @(posedge clk);
        #1;
        i_nrst        = r;
        i_wb_prog_cyc = pc;
        i_wb_cpu_cyc  = cc;
        i_wb_mem_ack  = ack;
        i_wb_mem_rdt  = rdt;
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input int owner, input logic mcyc,
                              input logic pack, input logic cack,
                              input logic [31:0] prdt, input logic [31:0] crdt, input logic to);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew;
        ea = '0; ed = '0; es = '0; ew = 1'b0;
        if (owner == 1) begin
            ea = i_wb_prog_adr; ed = i_wb_prog_dat; es = i_wb_prog_sel; ew = i_wb_prog_we;
        end else if (owner == 2) begin
            ea = i_wb_cpu_adr; ed = i_wb_cpu_dat; es = i_wb_cpu_sel; ew = i_wb_cpu_we;
        end
        chk({tag, " mem_adr"}, o_wb_mem_adr, ea);
        chk({tag, " mem_dat"}, o_wb_mem_dat, ed);
        chk({tag, " mem_sel"}, {28'b0, o_wb_mem_sel}, {28'b0, es});
        chk({tag, " mem_we"}, {31'b0, o_wb_mem_we}, {31'b0, ew});
        chk({tag, " mem_cyc"}, {31'b0, o_wb_mem_cyc}, {31'b0, mcyc});
        chk({tag, " prog_ack"}, {31'b0, o_wb_prog_ack}, {31'b0, pack});
        chk({tag, " cpu_ack"}, {31'b0, o_wb_cpu_ack}, {31'b0, cack});
        chk({tag, " busy"}, {31'b0, o_busy}, {31'b0, (owner != 0)});
        chk({tag, " prog_rdt"}, o_wb_prog_rdt, prdt);
        chk({tag, " cpu_rdt"}, o_wb_cpu_rdt, crdt);
        chk({tag, " timeout"}, {31'b0, o_timeout}, {31'b0, to});
    endtask

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int m_owner, m_last, m_age;
        logic m_to, gcyc, fire, epack, ecack;
        logic [31:0] eprdt, ecrdt;

        i_wb_prog_adr = 32'h0000_0100; i_wb_prog_dat = 32'h1234_5678;
        i_wb_prog_sel = 4'hF;          i_wb_prog_we  = 1'b1;
        i_wb_cpu_adr  = 32'h0000_0040; i_wb_cpu_dat  = 32'h0;
        i_wb_cpu_sel  = 4'hF;          i_wb_cpu_we   = 1'b0;

        // Single programmer write, then four contended transfers from reset
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h11, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 32'h22, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 1, 32'h33, 1, 1, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 32'h44, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1, 1, 32'h66, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 1, 32'h77, 1, 1, 1, 0);
        vecs[8]  = mk(1, 1, 1, 1, 32'h88, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 1, 32'h99, 2, 1, 0, 1);
        vecs[10] = mk(1, 1, 1, 1, 32'hAA, 0, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 1, 32'hBB, 1, 1, 1, 0);
        vecs[12] = mk(1, 1, 1, 1, 32'hCC, 0, 0, 0, 0);
        vecs[13] = mk(1, 1, 1, 1, 32'hDD, 2, 1, 0, 1);
        vecs[14] = mk(1, 0, 0, 0, 32'hEE, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].rst_n, vecs[i].pc, vecs[i].cc, vecs[i].ack, vecs[i].rdt);
            check_outs($sformatf("vec%0d", i), vecs[i].owner, vecs[i].mcyc,
                       vecs[i].pack, vecs[i].cack, vecs[i].rdt, vecs[i].rdt, 1'b0);
        end

        // CPU read with 3 wait states; programmer request arrives mid-transfer
        set_in(1, 0, 1, 0, 32'h0);          check_outs("rd_req",   0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 0, 1, 0, 32'h0);          check_outs("rd_w1",    2, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 1, 0, 32'h0);          check_outs("rd_w2",    2, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 1, 0, 32'h0);          check_outs("rd_w3",    2, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 1, 1, 32'hCAFEF00D);   check_outs("rd_ack",   2, 1, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        set_in(1, 1, 0, 0, 32'h0);          check_outs("rd_idle",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 0, 0, 32'h0);          check_outs("rd_pgnt",  1, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 0, 1, 32'h5);          check_outs("rd_pack",  1, 1, 1, 0, 32'h5, 32'h5, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("rd_end",   0, 0, 0, 0, 32'h0, 32'h0, 0);

        // CPU aborts after two wait cycles
        set_in(1, 0, 1, 0, 32'h0);          check_outs("ab_req",   0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 0, 1, 0, 32'h0);          check_outs("ab_w1",    2, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 0, 1, 0, 32'h0);          check_outs("ab_w2",    2, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("ab_drop",  2, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("ab_idle",  0, 0, 0, 0, 32'h0, 32'h0, 0);

        // Reset mid-transfer with last = programmer; next tie must still go to programmer
        set_in(1, 1, 0, 0, 32'h0);          check_outs("rs_req",   0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 0, 1, 32'h7);          check_outs("rs_ack",   1, 1, 1, 0, 32'h7, 32'h7, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("rs_idle",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 0, 0, 32'h0);          check_outs("rs_req2",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 0, 0, 32'h0);          check_outs("rs_gnt",   1, 1, 0, 0, 32'h0, 32'h0, 0);
        set_in(0, 1, 0, 0, 32'h0);          check_outs("rs_rst",   0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 1, 0, 32'h0);          check_outs("rs_tie",   0, 0, 0, 0, 32'h0, 32'h0, 0);
        set_in(1, 1, 1, 1, 32'h9);          check_outs("rs_tiegnt",1, 1, 1, 0, 32'h9, 32'h9, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("rs_end",   0, 0, 0, 0, 32'h0, 32'h0, 0);

`ifdef SERV_MEM_ARB_TIMEOUT_EN
        // Memory never acks: forced ack on the 8th granted cycle
        set_in(1, 1, 0, 0, 32'h55AA55AA);   check_outs("to_req", 0, 0, 0, 0, 32'h55AA55AA, 32'h55AA55AA, 0);
        for (int k = 1; k < TO; k++) begin
            set_in(1, 1, 0, 0, 32'h55AA55AA);
            check_outs($sformatf("to_wait%0d", k), 1, 1, 0, 0, 32'h55AA55AA, 32'h55AA55AA, 0);
        end
        set_in(1, 1, 0, 0, 32'h55AA55AA);   check_outs("to_fire", 1, 1, 1, 0, 32'hDEADBEEF, 32'h55AA55AA, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("to_flag", 0, 0, 0, 0, 32'h0, 32'h0, 1);
        set_in(1, 0, 1, 0, 32'h0);          check_outs("to_creq", 0, 0, 0, 0, 32'h0, 32'h0, 1);
        set_in(1, 0, 1, 1, 32'h0BADF00D);   check_outs("to_cack", 2, 1, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 1);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("to_stay", 0, 0, 0, 0, 32'h0, 32'h0, 1);
        set_in(0, 0, 0, 0, 32'h0);          check_outs("to_rst",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        // Real ack exactly on the 8th cycle wins over the watchdog
        set_in(1, 1, 0, 0, 32'h0);          check_outs("tr_req",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int k = 1; k < TO; k++) begin
            set_in(1, 1, 0, 0, 32'h0);
            check_outs($sformatf("tr_wait%0d", k), 1, 1, 0, 0, 32'h0, 32'h0, 0);
        end
        set_in(1, 1, 0, 1, 32'h600DDA7A);   check_outs("tr_ack",  1, 1, 1, 0, 32'h600DDA7A, 32'h600DDA7A, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("tr_end",  0, 0, 0, 0, 32'h0, 32'h0, 0);
`else
        // Without the watchdog a transfer waits indefinitely
        set_in(1, 1, 0, 0, 32'h0);          check_outs("nw_req",  0, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int k = 1; k <= 3 * TO; k++) begin
            set_in(1, 1, 0, 0, 32'h0);
            check_outs($sformatf("nw_wait%0d", k), 1, 1, 0, 0, 32'h0, 32'h0, 0);
        end
        set_in(1, 1, 0, 1, 32'h3);          check_outs("nw_ack",  1, 1, 1, 0, 32'h3, 32'h3, 0);
        set_in(1, 0, 0, 0, 32'h0);          check_outs("nw_end",  0, 0, 0, 0, 32'h0, 32'h0, 0);
`endif

        // Randomized traffic against a transfer-level model
        set_in(0, 0, 0, 0, 32'h0);          check_outs("rnd_rst", 0, 0, 0, 0, 32'h0, 32'h0, 0);
        m_owner = 0; m_last = 2; m_age = 0; m_to = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            i_nrst = 1'b1;
            if ($urandom_range(0, 3) == 0) i_wb_prog_cyc = ~i_wb_prog_cyc;
            if ($urandom_range(0, 3) == 0) i_wb_cpu_cyc  = ~i_wb_cpu_cyc;
            i_wb_prog_adr = $urandom; i_wb_prog_dat = $urandom;
            i_wb_prog_sel = 4'($urandom); i_wb_prog_we = 1'($urandom);
            i_wb_cpu_adr  = $urandom; i_wb_cpu_dat  = $urandom;
            i_wb_cpu_sel  = 4'($urandom); i_wb_cpu_we  = 1'($urandom);
            i_wb_mem_rdt  = $urandom;
            gcyc = (m_owner == 1) ? i_wb_prog_cyc : (m_owner == 2) ? i_wb_cpu_cyc : 1'b0;
            i_wb_mem_ack = gcyc && ($urandom_range(0, 3) == 0);
            fire  = TO_EN && gcyc && !i_wb_mem_ack && (m_age + 1 == TO);
            epack = (m_owner == 1) && (i_wb_mem_ack || fire);
            ecack = (m_owner == 2) && (i_wb_mem_ack || fire);
            eprdt = (m_owner == 1 && fire) ? 32'hDEADBEEF : i_wb_mem_rdt;
            ecrdt = (m_owner == 2 && fire) ? 32'hDEADBEEF : i_wb_mem_rdt;
            @(negedge clk);
            check_outs("rnd", m_owner, gcyc, epack, ecack, eprdt, ecrdt, m_to);
            if (m_owner == 0) begin
                if (i_wb_prog_cyc || i_wb_cpu_cyc) begin
                    if (i_wb_prog_cyc && i_wb_cpu_cyc) m_owner = (m_last == 1) ? 2 : 1;
                    else                               m_owner = i_wb_prog_cyc ? 1 : 2;
                    m_last = m_owner;
                    m_age  = 0;
                end
            end else begin
                m_age++;
                if (fire) m_to = 1'b1;
                if (i_wb_mem_ack || !gcyc || fire) m_owner = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serv_mem_arbiter.md
# serv_mem_arbiter

Two-master Wishbone arbiter that sits directly downstream of the SPI programming bridge. It merges the programmer's memory-write bus and the SERV CPU's merged instruction/data bus onto the single shared program/data memory port. Arbitration is round-robin and locked per transfer. An optional bus watchdog terminates transfers the memory never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transfer may wait for `i_wb_mem_ack` before forced termination; legal range ≥2.

Ports (clock and reset first):
- clk  input  1  system clock; all state on rising edge
- i_nrst  input  1  asynchronous, active-low reset
- i_wb_prog_adr  input  32  programmer address
- i_wb_prog_dat  input  32  programmer write data
- i_wb_prog_sel  input  4  programmer byte enables
- i_wb_prog_we  input  1  programmer write enable
- i_wb_prog_cyc  input  1  programmer request
- o_wb_prog_rdt  output  32  read data to programmer
- o_wb_prog_ack  output  1  transfer done, to programmer
- i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc  input  32/32/4/1/1  CPU master bus
- o_wb_cpu_rdt  output  32  read data to CPU
- o_wb_cpu_ack  output  1  transfer done, to CPU
- o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc  output  32/32/4/1/1  memory slave bus
- i_wb_mem_rdt  input  32  memory read data
- i_wb_mem_ack  input  1  memory acknowledge
- o_busy  output  1  high while a master is granted
- o_timeout  output  1  sticky watchdog flag

## Operation
- States: IDLE, PROG, CPU. Also holds a 1-bit `last` register naming the most recently granted master.
- IDLE:
  - Only prog_cyc high → PROG.
  - Only cpu_cyc high → CPU.
  - Both high → the master that is not `last`.
  - Neither high → stay in IDLE.
  - On grant, `last` is updated to the granted master.
- PROG/CPU: memory adr/dat/sel/we are driven combinationally from the granted master. o_wb_mem_cyc = granted master's cyc. In IDLE all o_wb_mem_* = 0.
- Read data: i_wb_mem_rdt is routed to both masters' rdt outputs unconditionally. Only the granted master receives ack (ack = i_wb_mem_ack in its state, else 0).
- Exit to IDLE occurs on the edge where any of these holds:
  - i_wb_mem_ack = 1.
  - The granted master drops cyc (abort). No ack is returned; o_wb_mem_cyc falls combinationally in that same cycle.
  - The watchdog fires.
- Grant is never changed mid-transfer: a request from the other master is held off until IDLE.
- Reset values: state IDLE, `last` = CPU (programmer wins the first tie), all outputs 0, watchdog counter 0, o_timeout 0.
- Reset mid-transfer: everything returns to reset values immediately. No ack is issued.

## Timing
- Arbitration latency: cyc first high in cycle N (state IDLE) → o_wb_mem_cyc high in cycle N+1.
- Ack is combinational: memory ack in cycle M → master ack in cycle M. State is IDLE in cycle M+1.
- Masters drop cyc in the cycle after ack. In IDLE, a still-high cyc in M+1 is treated as a new request.
- Minimum transfer with a zero-wait memory: 2 cycles per access (1 arbitration + 1 data).
- Back-to-back contention alternates PROG, CPU, PROG, … with one IDLE cycle between grants.
- o_busy = (state ≠ IDLE), decoded from the state register.

## Configuration
- Macro: SERV_MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1), cleared on grant.
  - Increments each granted cycle without i_wb_mem_ack.
  - In the granted cycle where counter = TIMEOUT_CYCLES−1 and i_wb_mem_ack = 0, the arbiter:
    - forces ack to the granted master for one cycle with rdt = 32'hDEADBEEF;
    - sets o_timeout (sticky until reset);
    - returns to IDLE.
  - A real ack in that same cycle wins: normal data, no flag.
- Undefined: no counter; a transfer waits indefinitely; o_timeout tied to 0.

## Test plan
- Reset then idle: all outputs 0, o_busy 0 → assert prog_cyc only; mem_cyc high one cycle later with prog adr 0x0000_0100, dat 0x1234_5678, sel 0xF, we 1; memory ack 1 cycle later → prog_ack pulses, cpu_ack stays 0.
- Simultaneous prog_cyc and cpu_cyc held high for 4 transfers, memory acks immediately → grant order PROG, CPU, PROG, CPU; each grant separated by one IDLE cycle.
- CPU read of 0x0000_0040 with memory returning 0xCAFEF00D after 3 wait cycles → cpu_ack in cycle 4 after grant with rdt 0xCAFEF00D; a prog request arriving mid-transfer is granted only after return to IDLE.
- With SERV_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, memory never acks → master ack on the 8th granted cycle with rdt 0xDEADBEEF; o_timeout = 1 and stays 1; next request is served normally. Repeat with ack on exactly the 8th cycle → real data, o_timeout 0.
- Master aborts (cyc low) after 2 wait cycles → mem_cyc low the same cycle, no ack, state IDLE next cycle. Repeat by pulsing i_nrst low mid-transfer → all outputs 0 immediately, next tie goes to the programmer.
